// File: rtl/div_remult_if.sv
// Operand/result handshake bundle for div_remult.
// The slave side is the checker; the master side is the driving or observing logic.
interface div_remult_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] q;
  logic [2:0] d;
  logic [2:0] r;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] x;
  logic       ovf;
  logic       div0;
  logic       rem_err;

  modport master (
    output in_valid, q, d, r, out_ready,
    input  in_ready, out_valid, x, ovf, div0, rem_err
  );

  modport slave (
    input  in_valid, q, d, r, out_ready,
    output in_ready, out_valid, x, ovf, div0, rem_err
  );
endinterface

// File: rtl/div_remult.sv
// Rebuilds a divider's dividend as x = q*d + r using three shift-and-add steps.
// It also flags triples that no legal 5-bit/3-bit division could have produced.
module div_remult (
  input logic        clk,
  input logic        rst,
  div_remult_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e     state_q, state_d;
  logic [2:0] q_reg_q, q_reg_d;
  logic [2:0] d_reg_q, d_reg_d;
  logic [5:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  // Flags captured at accept time; they are published together with x on entry to DONE.
  logic       div0_pend_q, div0_pend_d;
  logic       rem_err_pend_q, rem_err_pend_d;
  logic       ld_out;

  logic [5:0] x_q;
  logic       ovf_q, div0_q, rem_err_q;

  always_comb begin
    state_d        = state_q;
    q_reg_d        = q_reg_q;
    d_reg_d        = d_reg_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    div0_pend_d    = div0_pend_q;
    rem_err_pend_d = rem_err_pend_q;
    ld_out         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          q_reg_d        = bus.q;
          d_reg_d        = bus.d;
          acc_d          = {3'b000, bus.r};
          cnt_d          = 2'd0;
          div0_pend_d    = (bus.d == 3'd0);
          rem_err_pend_d = (bus.r >= bus.d);
          state_d        = StCalc;
        end
      end
      StCalc: begin
        // 6-bit accumulator: the largest sum, 7*7+7 = 56, cannot wrap.
        if (q_reg_q[cnt_q]) begin
          acc_d = acc_q + ({3'b000, d_reg_q} << cnt_q);
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) begin
          state_d = StDone;
          ld_out  = 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      q_reg_q        <= 3'd0;
      d_reg_q        <= 3'd0;
      acc_q          <= 6'd0;
      cnt_q          <= 2'd0;
      div0_pend_q    <= 1'b0;
      rem_err_pend_q <= 1'b0;
      x_q            <= 6'd0;
      ovf_q          <= 1'b0;
      div0_q         <= 1'b0;
      rem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      q_reg_q        <= q_reg_d;
      d_reg_q        <= d_reg_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      div0_pend_q    <= div0_pend_d;
      rem_err_pend_q <= rem_err_pend_d;
      if (ld_out) begin
        x_q       <= acc_d;
        ovf_q     <= acc_d[5];
        div0_q    <= div0_pend_q;
        rem_err_q <= rem_err_pend_q;
      end
    end
  end

  assign bus.in_ready  = (state_q == StIdle) & ~rst;
  assign bus.out_valid = (state_q == StDone);
  assign bus.x         = x_q;
  assign bus.ovf       = ovf_q;
  assign bus.div0      = div0_q;
  assign bus.rem_err   = rem_err_q;

endmodule

// File: tb/tb_div_remult.sv
// Bench for div_remult: a scoreboard of model results is filled at acceptance and
// drained as results appear.
module tb_div_remult;

  typedef struct packed {
    logic [5:0] x;
    logic       ovf;
    logic       div0;
    logic       rem_err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_remult_if bus ();

  div_remult dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t model(input int qi, input int di, input int ri);
    exp_t e;
    int   xv;
    xv        = qi * di + ri;
    e.x       = 6'(xv);
    e.ovf     = (xv > 31);
    e.div0    = (di == 0);
    e.rem_err = (ri >= di);
    return e;
  endfunction

  function automatic exp_t sample();
    return {bus.x, bus.ovf, bus.div0, bus.rem_err};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] qi, input logic [2:0] di, input logic [2:0] ri,
                       input bit push, output bit ok);
    int n;
    n            = 0;
    bus.q        = qi;
    bus.d        = di;
    bus.r        = ri;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
    if (ok && push) sb.push_back(model(qi, di, ri));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.q         = 3'd0;
    bus.d         = 3'd0;
    bus.r         = 3'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, sample()} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_state: got ov=%b ir=%b res=%h, want all 0",
               bus.out_valid, bus.in_ready, sample());
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b, want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    bit   ok;
    int   cyc;
    exp_t e;
    issue(3'd5, 3'd3, 3'd2, 1'b1, ok);
    wait_result(cyc);
    n_cmp++;
    if (!ok || cyc !== 3) begin
      n_err++;
      $display("FAIL basic_latency: got accepted=%b cycles=%0d, want 1/3", ok, cyc);
    end
    if (bus.out_valid && sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (sample() !== e || e !== {6'd17, 3'b000}) begin
        n_err++;
        $display("FAIL basic_result: got %h, want %h", sample(), e);
      end
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL basic_timeout: got out_valid=%b, want 1", bus.out_valid);
    end
    @(negedge clk);
  endtask

  // Overflow and divide-by-zero corner triples.
  task automatic test_corners();
    logic [8:0] tbl [4];
    bit   ok;
    int   cyc;
    exp_t e;
    tbl[0] = {3'd7, 3'd7, 3'd6};
    tbl[1] = {3'd7, 3'd7, 3'd7};
    tbl[2] = {3'd3, 3'd0, 3'd0};
    tbl[3] = {3'd0, 3'd4, 3'd4};
    for (int i = 0; i < 4; i++) begin
      issue(tbl[i][8:6], tbl[i][5:3], tbl[i][2:0], 1'b1, ok);
      wait_result(cyc);
      n_cmp++;
      if (!bus.out_valid || sb.size() == 0) begin
        n_err++;
        $display("FAIL corner_%0d_timeout: got out_valid=%b, want 1", i, bus.out_valid);
      end else begin
        e = sb.pop_front();
        if (sample() !== e) begin
          n_err++;
          $display("FAIL corner_%0d: got %h, want %h", i, sample(), e);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bit   ok;
    int   cyc;
    exp_t e;
    bus.out_ready = 1'b0;
    issue(3'd2, 3'd6, 3'd1, 1'b1, ok);
    wait_result(cyc);
    e = (sb.size() > 0) ? sb.pop_front() : exp_t'(0);
    n_cmp++;
    if (!bus.out_valid || sample() !== e) begin
      n_err++;
      $display("FAIL bp_result: got ov=%b %h, want 1 %h", bus.out_valid, sample(), e);
    end
    bus.q = 3'd7;
    bus.d = 3'd7;
    bus.r = 3'd7;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = i[0];
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, sample()} !== {2'b10, 6'd13, 3'b000}) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got ov=%b ir=%b %h, want 1 0 %h",
                 i, bus.out_valid, bus.in_ready, sample(), {6'd13, 3'b000});
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got ov=%b ir=%b, want 0 1", bus.out_valid, bus.in_ready);
    end
    cyc = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) cyc++;
    end
    n_cmp++;
    if (cyc !== 0 || bus.x !== 6'd13) begin
      n_err++;
      $display("FAIL bp_no_capture: got %0d stray results x=%0d, want 0 x=13", cyc, bus.x);
    end
  endtask

  task automatic test_reset_mid_calc();
    bit   ok;
    int   cyc;
    int   seen;
    exp_t e;
    issue(3'd4, 3'd5, 3'd0, 1'b0, ok);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, sample()} !== 11'd0) begin
      n_err++;
      $display("FAIL midrst_state: got ov=%b ir=%b %h, want all 0",
               bus.out_valid, bus.in_ready, sample());
    end
    rst  = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0 || sample() !== exp_t'(0)) begin
      n_err++;
      $display("FAIL midrst_quiet: got %0d results %h, want 0 results 0", seen, sample());
    end
    issue(3'd1, 3'd1, 3'd0, 1'b1, ok);
    wait_result(cyc);
    e = (sb.size() > 0) ? sb.pop_front() : exp_t'(0);
    n_cmp++;
    if (!bus.out_valid || cyc !== 3 || sample() !== e) begin
      n_err++;
      $display("FAIL midrst_next: got ov=%b cycles=%0d %h, want 1 3 %h",
               bus.out_valid, cyc, sample(), e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [8:0] ops [3];
    int   acc_t[$];
    int   idx;
    int   got_n;
    bit   just;
    exp_t e;
    ops[0] = {3'd3, 3'd5, 3'd1};
    ops[1] = {3'd6, 3'd2, 3'd0};
    ops[2] = {3'd1, 3'd7, 3'd6};
    idx    = 0;
    got_n  = 0;
    just   = 1'b0;
    bus.out_ready = 1'b1;
    {bus.q, bus.d, bus.r} = ops[0];
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && got_n < 3; cyc++) begin
      if (just) begin
        just = 1'b0;
        idx++;
        if (idx < 3) {bus.q, bus.d, bus.r} = ops[idx];
        else bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        got_n++;
        e = (sb.size() > 0) ? sb.pop_front() : exp_t'(0);
        n_cmp++;
        if (sample() !== e) begin
          n_err++;
          $display("FAIL b2b_result_%0d: got %h, want %h", got_n, sample(), e);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.q, bus.d, bus.r));
        acc_t.push_back(cyc);
        just = 1'b1;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (got_n !== 3 || acc_t.size() !== 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results %0d accepts, want 3 3", got_n, acc_t.size());
    end else if (acc_t[1] - acc_t[0] !== 5 || acc_t[2] - acc_t[1] !== 5) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d %0d, want 5 5",
               acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
    end
  endtask

  // Every legal 5-bit/3-bit division whose quotient fits in 3 bits.
  task automatic test_sweep();
    bit   ok;
    int   cyc;
    exp_t e;
    for (int xv = 0; xv < 32; xv++) begin
      for (int dv = 1; dv < 8; dv++) begin
        if (xv / dv > 7) continue;
        issue(3'(xv / dv), 3'(dv), 3'(xv % dv), 1'b1, ok);
        wait_result(cyc);
        e = (sb.size() > 0) ? sb.pop_front() : exp_t'(0);
        n_cmp++;
        if (!bus.out_valid || sample() !== e || sample() !== {6'(xv), 3'b000}) begin
          n_err++;
          $display("FAIL sweep_x%0d_d%0d: got ov=%b %h, want 1 %h",
                   xv, dv, bus.out_valid, sample(), {6'(xv), 3'b000});
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2 ms, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_sweep();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
